// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the memory responder
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ERR_RW_BOTH  = 0;
  localparam int ERR_UNSTABLE = 1;
  localparam int ERR_DROP     = 2;
  localparam int ERR_RANGE    = 3;
  localparam int ERR_ALIGN    = 4;

  // op is {write, read}
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;
  localparam logic [1:0] OP_BOTH = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  function automatic logic addr_in_range(logic [31:0] addr, int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - single-word memory request/response bundle
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic [15:0] errcode;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, errcode
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, errcode
  );
endinterface

// File: rtl/mem_responder_fsm.sv
// rtl/mem_responder_fsm.sv - request latch, latency counter and IDLE/WAIT/RESP sequencing
module mem_responder_fsm
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_valid,
  input  req_t   req_live,
  output state_t state,
  output req_t   req,
  output logic   rd_fire,
  output logic   wr_fire,
  output logic   resp
);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  req_t       req_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      req_q <= '0;
    end else if (state_q == IDLE && req_valid) begin
      cnt_q <= 4'(LATENCY - 1);
      req_q <= req_live;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In IDLE the live request is what gets latched at this edge, so the
  // LATENCY=1 read path sees the same fields as the latched copy would.
  always_comb begin
    state   = state_q;
    resp    = (state_q == RESP);
    rd_fire = (state_d == RESP) && (state_q != RESP);
    wr_fire = (state_q == RESP);
    req     = (state_q == IDLE) ? req_live : req_q;
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM responder with programmable latency and sticky error flags
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 6
) (
  input logic             clk,
  input logic             rst_n,
  mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       ram [DEPTH];
  logic [31:0]       rdata_q;
  logic [15:0]       err_q, err_set;
  logic              req_valid, rd_fire, wr_fire, resp, req_in_range;
  logic [ADDR_W-1:0] idx;
  req_t              req_live, req;
  state_t            state;

  assign req_valid = bus.mem_read | bus.mem_write;
  assign req_live  = {bus.mem_write, bus.mem_read, bus.mem_address,
                      bus.mem_wdata, bus.mem_byte_enable};

  mem_responder_fsm #(.LATENCY(LATENCY)) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_live  (req_live),
    .state     (state),
    .req       (req),
    .rd_fire   (rd_fire),
    .wr_fire   (wr_fire),
    .resp      (resp)
  );

  assign idx          = req.addr[ADDR_W+1:2];
  assign req_in_range = addr_in_range(req.addr, ADDR_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (wr_fire && req.op == OP_WR && req_in_range) begin
      for (int b = 0; b < 4; b++)
        if (req.be[b]) ram[idx][8*b +: 8] <= req.wdata[8*b +: 8];
    end
  end

  // Reads that hit a violation (both ops, out of range) return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else if (rd_fire && req.op != OP_WR)
      rdata_q <= (req.op == OP_RD && req_in_range) ? ram[idx] : 32'd0;
  end

  always_comb begin
    err_set = '0;
    if (state == IDLE) begin
      if (req_valid) begin
        err_set[ERR_RW_BOTH] = bus.mem_read & bus.mem_write;
        err_set[ERR_RANGE]   = !addr_in_range(bus.mem_address, ADDR_W);
        err_set[ERR_ALIGN]   = bus.mem_address[1:0] != 2'b00;
      end
    end else if (!req_valid) begin
      err_set[ERR_DROP] = 1'b1;
    end else begin
      err_set[ERR_UNSTABLE] = (req_live != req);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_q | err_set;
  end

  assign bus.mem_resp  = resp;
  assign bus.mem_rdata = rdata_q;
  assign bus.errcode   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench for mem_responder against a behavioural memory model
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  mem_responder_if bus2 ();

  assign {bus0.mem_read, bus0.mem_write, bus0.mem_byte_enable, bus0.mem_address, bus0.mem_wdata} = {rd, wr, be, addr, wdata};
  assign {bus1.mem_read, bus1.mem_write, bus1.mem_byte_enable, bus1.mem_address, bus1.mem_wdata} = {rd, wr, be, addr, wdata};
  assign {bus2.mem_read, bus2.mem_write, bus2.mem_byte_enable, bus2.mem_address, bus2.mem_wdata} = {rd, wr, be, addr, wdata};

  mem_responder #(.LATENCY(3),  .ADDR_W(6)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_responder #(.LATENCY(1),  .ADDR_W(6)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_responder #(.LATENCY(15), .ADDR_W(6)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [2:0]  resp;
  logic [31:0] rdv [3];
  logic [15:0] errv [3];
  assign resp    = {bus2.mem_resp, bus1.mem_resp, bus0.mem_resp};
  assign rdv[0]  = bus0.mem_rdata;
  assign rdv[1]  = bus1.mem_rdata;
  assign rdv[2]  = bus2.mem_rdata;
  assign errv[0] = bus0.errcode;
  assign errv[1] = bus1.errcode;
  assign errv[2] = bus2.errcode;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_m [64];
  logic [15:0] err_m;
  logic [31:0] rdata_m;

  int          lat_o;
  int          resp_cyc_o;
  logic [31:0] rdat_o;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mem_m[i]) mem_m[i] = '0;
    err_m   = '0;
    rdata_m = '0;
  endtask

  task automatic do_reset();
    rd = 0; wr = 0; be = '0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // mode 0: hold steady; 1: alter address in the first wait cycle; 2: drop request then.
  task automatic txn(int d, bit r, bit w, logic [3:0] b, logic [31:0] a,
                     logic [31:0] wd, int mode, bit hold);
    rd = r; wr = w; be = b; addr = a; wdata = wd;
    lat_o = -1;
    rdat_o = 'x;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (resp[d]) begin
        lat_o      = n;
        rdat_o     = rdv[d];
        resp_cyc_o = cyc;
        break;
      end
      @(posedge clk);
      #1;
      if (n == 0 && mode == 1) addr = a ^ 32'h8;
      if (n == 0 && mode == 2) begin rd = 0; wr = 0; end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      rd = 0; wr = 0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mtxn(string tag, bit r, bit w, logic [3:0] b, logic [31:0] a,
                      logic [31:0] wd, int mode, bit hold);
    logic in_rng;
    txn(0, r, w, b, a, wd, mode, hold);
    in_rng = (a >> 8) == 32'd0;
    if (r && w)           err_m[0] = 1'b1;
    if (!in_rng)          err_m[3] = 1'b1;
    if (a[1:0] != 2'b00)  err_m[4] = 1'b1;
    if (mode == 1)        err_m[1] = 1'b1;
    if (mode == 2)        err_m[2] = 1'b1;
    if (r && w) rdata_m = '0;
    else if (r) rdata_m = in_rng ? mem_m[a[7:2]] : 32'd0;
    else if (in_rng) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mem_m[a[7:2]][8*i +: 8] = wd[8*i +: 8];
    end
    check({tag, ":lat"},   lat_o,   32'd3);
    check({tag, ":rdata"}, rdat_o,  rdata_m);
    check({tag, ":err"},   {16'd0, errv[0]}, {16'd0, err_m});
  endtask

  initial begin
    int c1, nresp;
    logic [31:0] a, v;
    int k;
    bit r;

    do_reset();
    @(negedge clk);
    check("reset:resp",  {29'd0, resp}, 32'd0);
    check("reset:rdata", rdv[0], 32'd0);
    check("reset:err",   {16'd0, errv[0]}, 32'd0);
    @(posedge clk); #1;

    mtxn("wr10", 0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0);
    mtxn("rd10", 1, 0, 4'h0, 32'h10, 32'h0, 0, 0);
    check("rd10:const", rdat_o, 32'hDEADBEEF);
    mtxn("wr_be", 0, 1, 4'b0101, 32'h10, 32'h11223344, 0, 0);
    mtxn("rd_be", 1, 0, 4'h0, 32'h10, 32'h0, 0, 0);
    check("rd_be:const", rdat_o, 32'hDE22BE44);

    mtxn("b2b_a", 1, 0, 4'h0, 32'h10, 32'h0, 0, 1);
    c1 = resp_cyc_o;
    mtxn("b2b_b", 1, 0, 4'h0, 32'h14, 32'h0, 0, 0);
    check("b2b:gap", resp_cyc_o - c1, 32'd4);
    check("b2b:rdata", rdat_o, 32'd0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 15);
      r = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 15)) << 2;
      if (k == 1) a = a | 32'($urandom_range(1, 3));
      if (k == 2) a = a | (32'h100 << $urandom_range(0, 23));
      mtxn("rand", r || k == 0, !r || k == 0, 4'($urandom_range(0, 15)), a,
           $urandom, 0, 1'($urandom_range(0, 1)));
    end

    do_reset();
    mtxn("v_wr20", 0, 1, 4'hF, 32'h20, 32'h5A5A1234, 0, 0);
    mtxn("v_both", 1, 1, 4'hF, 32'h20, 32'hFFFFFFFF, 0, 0);
    check("v_both:err", {16'd0, errv[0]}, 32'h1);
    mtxn("v_rd20", 1, 0, 4'h0, 32'h20, 32'h0, 0, 0);
    check("v_rd20:const", rdat_o, 32'h5A5A1234);
    mtxn("v_wr10", 0, 1, 4'hF, 32'h10, 32'h0BADCAFE, 0, 0);
    mtxn("v_range", 1, 0, 4'h0, 32'h1000, 32'h0, 0, 0);
    check("v_range:bit3", {31'd0, errv[0][3]}, 32'd1);
    mtxn("v_align", 1, 0, 4'h0, 32'h13, 32'h0, 0, 0);
    check("v_align:data", rdat_o, 32'h0BADCAFE);
    mtxn("v_chg", 0, 1, 4'hF, 32'h10, 32'h77778888, 1, 0);
    mtxn("v_chg_rd10", 1, 0, 4'h0, 32'h10, 32'h0, 0, 0);
    mtxn("v_chg_rd18", 1, 0, 4'h0, 32'h18, 32'h0, 0, 0);
    mtxn("v_drop", 1, 0, 4'h0, 32'h10, 32'h0, 2, 0);
    check("v_drop:bit2", {31'd0, errv[0][2]}, 32'd1);

    do_reset();
    rd = 0; wr = 1; be = 4'hF; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rd = 0; wr = 0; rst_n = 1'b1;
    model_clear();
    nresp = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp[0]) nresp++;
    end
    @(posedge clk); #1;
    check("rstmid:noresp", nresp, 32'd0);
    mtxn("rstmid_rd30", 1, 0, 4'h0, 32'h30, 32'h0, 0, 0);

    do_reset();
    txn(1, 0, 1, 4'hF, 32'h24, 32'h13572468, 0, 0);
    check("lat1:wr_lat", lat_o, 32'd1);
    txn(1, 1, 0, 4'h0, 32'h24, 32'h0, 0, 0);
    check("lat1:rd_lat", lat_o, 32'd1);
    check("lat1:rdata", rdat_o, 32'h13572468);

    do_reset();
    txn(2, 0, 1, 4'hF, 32'h24, 32'h2468ACE0, 0, 0);
    check("lat15:wr_lat", lat_o, 32'd15);
    txn(2, 1, 0, 4'h0, 32'h24, 32'h0, 0, 0);
    check("lat15:rd_lat", lat_o, 32'd15);
    check("lat15:rdata", rdat_o, 32'h2468ACE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
